// File: rtl/dsram_bridge.sv
// Converts single-cycle core data-SRAM accesses into req/addr_ok/data_ok memory transactions,
// stalling the pipeline until completion and counting stalled cycles (saturating).
module dsram_bridge #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic             stallreq_for_mem,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic             req_q;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [1:0]       size_d;
  logic [3:0]       wstrb_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stall;
  logic             finish;

  always_comb begin
    size_d = 2'd2;
    case (data_sram_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_d = 2'd0;
      4'b0011, 4'b1100:                   size_d = 2'd1;
      default:                            size_d = 2'd2;
    endcase
  end

  assign stall  = (state_q == S_IDLE && data_sram_en) || state_q == S_REQ || state_q == S_WAIT;
  // The access completes either together with acceptance or later in WAIT.
  assign finish = (state_q == S_REQ && mem_addr_ok && mem_data_ok) ||
                  (state_q == S_WAIT && mem_data_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= '0;
    end else begin
      if (stall && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      if (finish && !wr_q) rdata_q <= mem_rdata;
      case (state_q)
        S_IDLE: if (data_sram_en) begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          wr_q    <= |data_sram_wen;
          size_q  <= size_d;
          wstrb_q <= data_sram_wen;
          addr_q  <= data_sram_addr;
          wdata_q <= data_sram_wdata;
        end
        S_REQ: if (mem_addr_ok) begin
          req_q   <= 1'b0;
          state_q <= mem_data_ok ? S_DONE : S_WAIT;
        end
        S_WAIT: if (mem_data_ok) state_q <= S_DONE;
        // EX still holds the same instruction here, so en must not start a new access.
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallreq_for_mem = stall;
  assign mem_req          = req_q;
  assign mem_wr           = wr_q;
  assign mem_size         = size_q;
  assign mem_wstrb        = wstrb_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign data_sram_rdata  = rdata_q;
  assign stall_cycles     = cnt_q;

endmodule

// File: tb/tb_dsram_bridge.sv
// Bench acts as core and memory; each access is scheduled from its chosen handshake delays.
module tb_dsram_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        stallreq_for_mem, mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] stall_cycles;

  logic        s_stall, s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  s_cnt;

  int n_cmp = 0, n_fail = 0;

  logic        exp_stall = 1'b0, exp_req = 1'b0, exp_rstvals = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  longint      exp_cnt = 0;
  logic [3:0]  t_wen = 4'd0;
  logic [31:0] t_addr = 32'd0, t_wdata = 32'd0;

  int          obs_stall, obs_req;
  logic        seen, unstable;
  logic [70:0] last_f;

  always #5 clk = ~clk;

  dsram_bridge #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_for_mem(stallreq_for_mem),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .stall_cycles(stall_cycles));

  dsram_bridge #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(s_rdata), .stallreq_for_mem(s_stall),
    .mem_req(s_req), .mem_wr(s_wr), .mem_size(s_size), .mem_wstrb(s_wstrb),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .stall_cycles(s_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] size_of(input logic [3:0] wen);
    if (wen == 4'b0000) return 2'd2;
    if ($countones(wen) == 1) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Compare process: every non-reset cycle against the scheduled expectations.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
    end else begin
      chk("stallreq", stallreq_for_mem, exp_stall);
      chk("sat_stallreq", s_stall, exp_stall);
      chk("mem_req", mem_req, exp_req);
      chk("sat_mem_req", s_req, exp_req);
      chk("rdata", data_sram_rdata, exp_rdata);
      chk("sat_rdata", s_rdata, exp_rdata);
      chk("stall_cycles", stall_cycles, exp_cnt);
      chk("sat_cycles", s_cnt, (exp_cnt > 7) ? 64'd7 : exp_cnt);
      if (exp_req) begin
        chk("mem_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
            {t_wen != 4'd0, size_of(t_wen), t_wen, t_addr, t_wdata});
        chk("sat_fields", {s_wr, s_size, s_wstrb, s_addr, s_wdata},
            {t_wen != 4'd0, size_of(t_wen), t_wen, t_addr, t_wdata});
      end
      if (exp_rstvals)
        chk("reset_fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, 64'd0);
      if (exp_stall) exp_cnt++;
    end
  end

  task automatic drive_cycle(input logic r, input logic e, input logic [3:0] wn,
                             input logic [31:0] ad, input logic [31:0] wd,
                             input logic aok, input logic dok, input logic [31:0] rd,
                             input logic es, input logic er, input logic rv);
    rst = r; data_sram_en = e; data_sram_wen = wn; data_sram_addr = ad;
    data_sram_wdata = wd; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    exp_stall = es; exp_req = er; exp_rstvals = rv;
    @(negedge clk);
    obs_stall += int'(stallreq_for_mem);
    obs_req   += int'(mem_req);
    if (mem_req) begin
      if (seen && last_f != {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}) unstable = 1'b1;
      last_f = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};
      seen = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 4'($urandom), $urandom, $urandom, 1'b0, 1'($urandom),
                $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // One access: IDLE-with-en, a+1 REQ cycles, d WAIT cycles, DONE. rst_wait>0 resets in that WAIT cycle.
  task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int a, input int d, input int rst_wait);
    logic dok;
    obs_stall = 0; obs_req = 0; seen = 1'b0; unstable = 1'b0;
    t_wen = wen; t_addr = addr; t_wdata = wd;
    drive_cycle(1'b0, 1'b1, wen, addr, wd, 1'b0, 1'($urandom), $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= a; i++) begin
      dok = (i == a && d == 0);
      drive_cycle(1'b0, 1'b1, wen, addr, wd, i == a, dok, dok ? rdata : $urandom,
                  1'b1, 1'b1, 1'b0);
    end
    for (int j = 1; j <= d; j++) begin
      if (j == rst_wait) begin
        exp_rdata = 32'd0;
        drive_cycle(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        return;
      end
      dok = (j == d);
      drive_cycle(1'b0, 1'b1, wen, addr, wd, 1'b0, dok, dok ? rdata : $urandom,
                  1'b1, 1'b0, 1'b0);
    end
    if (wen == 4'd0) exp_rdata = rdata;
    drive_cycle(1'b0, 1'b1, wen, addr, wd, 1'b0, 1'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    exp_rdata = 32'd0;
    drive_cycle(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [3:0] wen_tbl [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0011, 4'b1100, 4'b1111, 4'b0111, 4'b0000};

  initial begin
    rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'd0; data_sram_addr = 32'd0;
    data_sram_wdata = 32'd0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Zero-wait read
    run_txn(4'b0000, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    chk("rd0_stalls", obs_stall, 2);
    chk("rd0_reqs", obs_req, 1);
    chk("rd0_size_wr", last_f[70:68], 3'b0_10);
    chk("rd0_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("rd0_count", stall_cycles, 2);
    idle_cycle();

    // Byte write, addr_ok after 3 REQ cycles, data_ok 2 later
    run_txn(4'b0100, 32'h8000_0013, 32'h00AB_0000, 32'h0, 2, 2, 0);
    chk("bw_reqs", obs_req, 3);
    chk("bw_stalls", obs_stall, 6);
    chk("bw_stable", unstable, 0);
    chk("bw_size_wstrb", last_f[70:64], 7'b1_00_0100);
    chk("bw_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("bw_count", stall_cycles, 8);
    chk("bw_sat_count", s_cnt, 7);
    idle_cycle();

    // Half write
    run_txn(4'b1100, 32'h0000_0102, 32'h1234_0000, 32'h0, 0, 1, 0);
    chk("hw_fields", last_f[70:64], 7'b1_01_1100);
    idle_cycle();

    // Back-to-back loads
    run_txn(4'b0000, 32'h0000_0200, 32'h0, 32'h1111_2222, 1, 1, 0);
    chk("b2b_reqs1", obs_req, 2);
    run_txn(4'b0000, 32'h0000_0204, 32'h0, 32'h3333_4444, 0, 2, 0);
    chk("b2b_reqs2", obs_req, 1);
    chk("b2b_rdata", data_sram_rdata, 32'h3333_4444);
    idle_cycle();

    // Reset while waiting for data
    run_txn(4'b0000, 32'h0000_0300, 32'h0, 32'h5555_6666, 0, 3, 2);
    chk("rst_count", stall_cycles, 0);
    chk("rst_rdata", data_sram_rdata, 0);
    chk("rst_req", mem_req, 0);

    // Saturation: memory silent for 10 stall cycles
    run_txn(4'b0000, 32'h0000_0400, 32'h0, 32'h7777_8888, 9, 0, 0);
    chk("sat_small", s_cnt, 7);
    chk("sat_big", stall_cycles, 11);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      run_txn(wen_tbl[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dsram_bridge.md
# dsram_bridge

Data-side memory bridge between the pipeline core's single-cycle data SRAM port and a split-handshake (req/addr_ok/data_ok) memory port. It sits directly downstream of the core, taking `data_sram_*` from EX and returning `data_sram_rdata` to MEM. It converts every access into one handshaked transaction and holds the pipeline through CTRL's stall request until the transaction completes. It also keeps a saturating count of cycles spent stalled.

## Interface
- `CNT_W`, 32, width of the stall-cycle counter.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `data_sram_en` in 1: core access request, valid while the instruction is in EX.
- `data_sram_wen` in 4: byte write enables; 0000 means read.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: write data, already lane-aligned by the core.
- `data_sram_rdata` out 32: read data to MEM; registered.
- `stallreq_for_mem` out 1: stall request to CTRL; freezes IF through EX.
- `mem_req` out 1: memory request valid.
- `mem_wr` out 1: 1 = write.
- `mem_size` out 2: 0 = byte, 1 = half, 2 = word.
- `mem_wstrb` out 4: byte strobes.
- `mem_addr` out 32: request address.
- `mem_wdata` out 32: request write data.
- `mem_addr_ok` in 1: request accepted this cycle (when `mem_req`=1).
- `mem_data_ok` in 1: read data valid / write complete this cycle.
- `mem_rdata` in 32: read data, valid when `mem_data_ok`=1.
- `stall_cycles` out CNT_W: count of cycles with `stallreq_for_mem`=1; saturates.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `data_sram_en`=1: capture wen/addr/wdata into request registers and go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `mem_req`=1, with fields driven from the request registers (stable while in REQ).
  - If `mem_addr_ok`=1 and `mem_data_ok`=1 together: go to DONE.
  - If only `mem_addr_ok`=1: go to WAIT.
  - Otherwise stay in REQ.
- **WAIT**
  - `mem_req`=0.
  - On `mem_data_ok`=1: go to DONE.
- **DONE**
  - Lasts exactly one cycle, then goes to IDLE.
  - `data_sram_en` is ignored here: the same instruction is still in EX, so the access is not reissued.
- Stall request: `stallreq_for_mem` = (IDLE & `data_sram_en`) | REQ | WAIT. It is combinational from the state and `data_sram_en`.
- Read data: on `mem_data_ok`=1 with a read outstanding, `data_sram_rdata` <= `mem_rdata`. It holds until the next read completes; writes leave it unchanged.
- Field mapping from the captured wen (`mem_addr` = captured addr, unmodified; `mem_wdata` = captured wdata):
  - 0000: `mem_wr`=0, `mem_size`=2, `mem_wstrb`=0000.
  - 0001, 0010, 0100, 1000: `mem_wr`=1, `mem_size`=0.
  - 0011, 1100: `mem_wr`=1, `mem_size`=1.
  - Any other nonzero wen: `mem_wr`=1, `mem_size`=2.
  - For every write, `mem_wstrb` = wen.
- Stall counter: `stall_cycles` increments by 1 every cycle with `stallreq_for_mem`=1 and holds at all ones.
- A `mem_data_ok` seen in IDLE or DONE is ignored; it does not change state or `data_sram_rdata`.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`=0, `mem_wr`=0, `mem_size`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - `data_sram_rdata`=0.
  - `stall_cycles`=0.
  - `stallreq_for_mem`=0 as long as `data_sram_en`=0.
- Reset mid-transaction: abandon the transaction and go to IDLE on the next edge. The memory side shares `rst`, so no stale `data_ok` arrives.
- Minimum latency, with memory answering in the first REQ cycle:
  - Cycle 0: IDLE with `en` → stall.
  - Cycle 1: REQ with addr_ok and data_ok both 1 → stall.
  - Cycle 2: DONE → no stall.
  - Total: 2 stall cycles. The instruction enters MEM at the end of cycle 2, and `data_sram_rdata` is valid from cycle 2 on.
- General: stall cycles = 1 + (REQ cycles) + (WAIT cycles).
- Back-to-back accesses: the next instruction appears in EX in the cycle after DONE (IDLE), so there is no bubble beyond DONE.
- `mem_req` never drops in REQ before `mem_addr_ok`.

## Test plan
- **Read, zero wait.**
  - Stimulus: en=1, wen=0000, addr=0x8000_0010; memory returns addr_ok=data_ok=1 in the first REQ cycle with rdata=0xDEAD_BEEF.
  - Required: 2 stall cycles; `mem_size`=2, `mem_wr`=0; `data_sram_rdata`=0xDEAD_BEEF from the DONE cycle on; `stall_cycles`=2.
- **Byte write, delayed handshake.**
  - Stimulus: wen=0100, addr=0x...3, wdata=0x00AB_0000; addr_ok after 3 REQ cycles, data_ok 2 cycles later.
  - Required: `mem_req` high for exactly 3 cycles with fields stable; `mem_size`=0, `mem_wstrb`=0100; 1+3+2 = 6 stall cycles; `data_sram_rdata` unchanged.
- **Half write.**
  - Stimulus: wen=1100.
  - Required: `mem_size`=1, `mem_wstrb`=1100, `mem_wr`=1.
- **Back-to-back loads.**
  - Stimulus: two loads in consecutive EX slots.
  - Required: exactly one transaction per load; no reissue during DONE; second rdata replaces first only on the second data_ok.
- **Reset in WAIT.**
  - Stimulus: assert rst for 1 cycle while in WAIT.
  - Required: next cycle state IDLE, all outputs at reset values, stall=0 with en=0.
- **Counter saturation.**
  - Stimulus: CNT_W=3, hold memory silent for 10 stall cycles.
  - Required: `stall_cycles` stops at 7.
